player_status_ctrl: RTL

Playback status controller that produces the elapsed-time, volume and track-index words consumed by the seven-segment scan driver (`DATA` in seconds for mm:ss, `VOL` in 0x0000/0x1010..0xF0F0 form, `CURRENT` 0..7). It turns already-debounced front-panel button levels into play/pause/stop state, track navigation and volume steps. It runs a 1-second tick so that `DATA` advances while playing. It also pulses `TRACK_START` to tell the audio source to restart at the current track.

---
 rtl/player_pkg.sv | 18 +
 rtl/player_status_ctrl_if.sv | 23 ++
 rtl/sec_tick_gen.sv | 36 +++
 rtl/player_status_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the playback status controller.
package player_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2
   } play_state_e;

   localparam logic [3:0] VOL_RESET_ATT  = 4'd8;
   localparam int         RESTART_THRESH = 3;

   // Attenuation is shown twice so the scan driver can read either byte.
   function automatic logic [15:0] vol_encode(input logic [3:0] att);
      return {att, 4'h0, att, 4'h0};
   endfunction

endpackage

// File: rtl/player_status_ctrl_if.sv
// Front-panel buttons and display-status words exchanged with the status controller.
interface player_status_ctrl_if;
   logic        btn_play;
   logic        btn_next;
   logic        btn_prev;
   logic        btn_vup;
   logic        btn_vdn;
   logic [15:0] data;
   logic [15:0] vol;
   logic [2:0]  current;
   logic        playing;
   logic        track_start;

   // master drives the buttons (panel side); slave produces the status words.
   modport master (
      output btn_play, btn_next, btn_prev, btn_vup, btn_vdn,
      input  data, vol, current, playing, track_start
   );
   modport slave (
      input  btn_play, btn_next, btn_prev, btn_vup, btn_vdn,
      output data, vol, current, playing, track_start
   );
endinterface

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts while enabled, holds while disabled, clears on demand.
module sec_tick_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int             CW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0]  LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/player_status_ctrl.sv
// Turns debounced button levels into play state, elapsed time, track index and volume
// words for the seven-segment scan driver.
module player_status_ctrl
   import player_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int TRACK_LEN  = 240,
   parameter int NUM_TRACKS = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        BTN_PLAY,
   input  logic        BTN_NEXT,
   input  logic        BTN_PREV,
   input  logic        BTN_VUP,
   input  logic        BTN_VDN,
   output logic [15:0] DATA,
   output logic [15:0] VOL,
   output logic [2:0]  CURRENT,
   output logic        PLAYING,
   output logic        TRACK_START
);

   localparam logic [15:0] DATA_LAST  = 16'(TRACK_LEN - 1);
   localparam logic [2:0]  LAST_TRACK = 3'(NUM_TRACKS - 1);

   logic [4:0]  btn_lvl;
   logic [4:0]  btn_prev_q;
   logic [4:0]  btn_edge;
   logic        e_play, e_next, e_prev, e_vup, e_vdn;

   play_state_e state_q, state_d;
   logic [15:0] data_q, data_d;
   logic [2:0]  cur_q, cur_d;
   logic [3:0]  att_q, att_d;
   logic        playing_q, playing_d;
   logic        track_start_q, track_start_d;

   logic        tick;
   logic        tick_en, tick_clr;
   logic        tick_use;
   logic        nav_restart;

   assign btn_lvl  = {BTN_PLAY, BTN_NEXT, BTN_PREV, BTN_VUP, BTN_VDN};
   assign btn_edge = btn_lvl & ~btn_prev_q;
   assign {e_play, e_next, e_prev, e_vup, e_vdn} = btn_edge;

   // Any manual navigation restarts the second count so the new track gets a full first second.
   assign tick_en  = (state_q == PLAY);
   assign tick_clr = e_next || e_prev || (state_q == STOP);

   sec_tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick (
      .CLK  (CLK),
      .RST  (RST),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick)
   );

   assign tick_use = tick && !e_next && !e_prev;

   always_comb begin
      data_d      = data_q;
      cur_d       = cur_q;
      nav_restart = 1'b0;

      if (e_next) begin
         cur_d       = (cur_q == LAST_TRACK) ? 3'd0 : cur_q + 3'd1;
         data_d      = '0;
         nav_restart = 1'b1;
      end else if (e_prev) begin
         if (data_q < 16'(RESTART_THRESH)) begin
            cur_d = (cur_q == 3'd0) ? LAST_TRACK : cur_q - 3'd1;
         end
         data_d      = '0;
         nav_restart = 1'b1;
      end else if (tick_use) begin
         if (data_q < DATA_LAST) begin
            data_d = data_q + 16'd1;
         end else begin
            data_d      = '0;
            cur_d       = (cur_q == LAST_TRACK) ? 3'd0 : cur_q + 3'd1;
            nav_restart = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (e_play) begin
         case (state_q)
            STOP:    state_d = PLAY;
            PLAY:    state_d = PAUSE;
            PAUSE:   state_d = PLAY;
            default: state_d = STOP;
         endcase
      end
      playing_d = (state_d == PLAY);
      // Resuming from PAUSE keeps the audio position, so only a fresh start or a track change pulses.
      track_start_d = (state_d == PLAY) && (nav_restart || (state_q == STOP));
   end

   always_comb begin
      att_d = att_q;
      if (e_vup && !e_vdn && (att_q != 4'd0)) begin
         att_d = att_q - 4'd1;
      end else if (e_vdn && !e_vup && (att_q != 4'd15)) begin
         att_d = att_q + 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         btn_prev_q    <= '1;
         state_q       <= STOP;
         data_q        <= '0;
         cur_q         <= '0;
         att_q         <= VOL_RESET_ATT;
         playing_q     <= 1'b0;
         track_start_q <= 1'b0;
      end else begin
         btn_prev_q    <= btn_lvl;
         state_q       <= state_d;
         data_q        <= data_d;
         cur_q         <= cur_d;
         att_q         <= att_d;
         playing_q     <= playing_d;
         track_start_q <= track_start_d;
      end
   end

   assign DATA        = data_q;
   assign VOL         = vol_encode(att_q);
   assign CURRENT     = cur_q;
   assign PLAYING     = playing_q;
   assign TRACK_START = track_start_q;

endmodule
